// File: rtl/uart_pkt_ctrl.sv
// Packet framer between a UART receiver and the BNN loader: SYNC, CMD, LEN, payload, XOR checksum.
// A good packet is buffered and then drained to the loader with valid/ready handshaking.
module uart_pkt_ctrl #(
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = 8'hA5
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic       rts,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] pkt_cmd,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK, S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cmd_q, cmd_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      chk_q, chk_d;
    logic [IW-1:0]   wr_q, wr_d;
    logic [IW-1:0]   rd_q, rd_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            wr_en;
    logic            fail;
    logic [1:0]      fail_code;
    logic [7:0]      mem_q [MAX_LEN];

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath; a frame error outranks every content check.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        chk_d     = chk_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        wr_en     = 1'b0;
        fail      = 1'b0;
        fail_code = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid && !rx_frame_err && rx_data == SYNC) begin
                    state_d = S_CMD;
                    chk_d   = 8'd0;
                    wr_d    = '0;
                    rd_d    = '0;
                end
            end
            S_CMD, S_LEN, S_PAY, S_CHK: begin
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        fail      = 1'b1;
                        fail_code = 2'd1;
                    end else begin
                        case (state_q)
                            S_CMD: begin
                                if (rx_data[7:2] == 6'd0) begin
                                    cmd_d   = rx_data[1:0];
                                    chk_d   = chk_q ^ rx_data;
                                    state_d = S_LEN;
                                end else begin
                                    fail      = 1'b1;
                                    fail_code = 2'd2;
                                end
                            end
                            S_LEN: begin
                                if (rx_data != 8'd0 && int'(rx_data) <= MAX_LEN) begin
                                    len_d   = rx_data;
                                    chk_d   = chk_q ^ rx_data;
                                    state_d = S_PAY;
                                end else begin
                                    fail      = 1'b1;
                                    fail_code = 2'd2;
                                end
                            end
                            S_PAY: begin
                                wr_en = 1'b1;
                                chk_d = chk_q ^ rx_data;
                                if (8'(wr_q) == len_q - 8'd1) state_d = S_CHK;
                                else                          wr_d    = wr_q + IW'(1);
                            end
                            default: begin
                                if (rx_data == chk_q) begin
                                    state_d = S_DRAIN;
                                    rd_d    = '0;
                                end else begin
                                    fail      = 1'b1;
                                    fail_code = 2'd3;
                                end
                            end
                        endcase
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (8'(rd_q) == len_q - 8'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fail) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = fail_code;
        end
    end

    always_ff @(posedge baud_clk or posedge rst) begin
        if (rst) begin
            cmd_q  <= 2'd0;
            len_q  <= 8'd0;
            chk_q  <= 8'd0;
            wr_q   <= '0;
            rd_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= 2'd0;
        end else begin
            cmd_q  <= cmd_d;
            len_q  <= len_d;
            chk_q  <= chk_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            done_q <= done_d;
            err_q  <= err_d;
            code_q <= code_d;
        end
    end

    // Payload storage needs no reset: it is only read in DRAIN, after a full fill.
    always_ff @(posedge baud_clk) begin
        if (wr_en) mem_q[wr_q] <= rx_data;
    end

    always_comb begin
        rts       = (state_q != S_DRAIN);
        out_valid = (state_q == S_DRAIN);
        out_data  = (state_q == S_DRAIN) ? mem_q[rd_q] : 8'd0;
        pkt_cmd   = cmd_q;
        pkt_done  = done_q;
        pkt_err   = err_q;
        err_code  = code_q;
    end

endmodule

// File: tb/tb_uart_pkt_ctrl.sv
// Randomised bench for uart_pkt_ctrl: byte-stream reference model plus directed packet scenarios.
module tb_uart_pkt_ctrl;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;

    typedef logic [7:0] u8;

    logic       baud_clk, rst;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err;
    logic       rts;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [1:0] pkt_cmd;
    logic       pkt_done, pkt_err;
    logic [1:0] err_code;

    uart_pkt_ctrl #(.MAX_LEN(MAX_LEN), .SYNC(SYNC)) dut (
        .baud_clk(baud_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_err(rx_frame_err), .rts(rts), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .pkt_cmd(pkt_cmd), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .err_code(err_code)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: packet bytes collected since SYNC, and the payload queue still to drain.
    bit         m_hunt;
    u8          m_pkt[$];
    u8          m_drain[$];
    logic [1:0] m_cmd, m_code;
    logic       m_done, m_perr;

    // Observation log for directed checks.
    u8  got[$];
    u8  exp_q[$];
    u8  stim[$];
    int c_done, c_err, c_valid;
    logic [1:0] last_cmd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hunt = 1'b1;
        m_pkt.delete();
        m_drain.delete();
        m_cmd  = 2'd0;
        m_code = 2'd0;
        m_done = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic m_fail(input logic [1:0] c);
        m_perr = 1'b1;
        m_code = c;
        m_hunt = 1'b1;
        m_pkt.delete();
    endtask

    task automatic model_step(input bit v, input u8 d, input bit fe, input bit rdy);
        u8 x;
        m_done = 1'b0;
        m_perr = 1'b0;
        if (m_drain.size() != 0) begin
            if (rdy) begin
                void'(m_drain.pop_front());
                if (m_drain.size() == 0) m_done = 1'b1;
            end
        end else if (v) begin
            if (m_hunt) begin
                if (!fe && d == SYNC) begin
                    m_hunt = 1'b0;
                    m_pkt.delete();
                end
            end else if (fe) begin
                m_fail(2'd1);
            end else if (m_pkt.size() == 0) begin
                if (d[7:2] != 6'd0) m_fail(2'd2);
                else begin
                    m_cmd = d[1:0];
                    m_pkt.push_back(d);
                end
            end else if (m_pkt.size() == 1) begin
                if (d == 8'd0 || int'(d) > MAX_LEN) m_fail(2'd2);
                else m_pkt.push_back(d);
            end else if (m_pkt.size() < int'(m_pkt[1]) + 2) begin
                m_pkt.push_back(d);
            end else begin
                x = 8'd0;
                foreach (m_pkt[i]) x = x ^ m_pkt[i];
                if (x == d) begin
                    for (int i = 2; i < m_pkt.size(); i++) m_drain.push_back(m_pkt[i]);
                    m_hunt = 1'b1;
                    m_pkt.delete();
                end else begin
                    m_fail(2'd3);
                end
            end
        end
    endtask

    task automatic compare();
        bit ev;
        ev = (m_drain.size() != 0);
        chk("rts", rts, !ev);
        chk("out_valid", out_valid, ev);
        if (ev) begin
            chk("out_data", out_data, m_drain[0]);
            chk("pkt_cmd", pkt_cmd, m_cmd);
        end else if (rst) begin
            chk("rst_out_data", out_data, 0);
            chk("rst_pkt_cmd", pkt_cmd, 0);
        end
        chk("pkt_done", pkt_done, m_done);
        chk("pkt_err", pkt_err, m_perr);
        chk("err_code", err_code, m_code);
    endtask

    // One clock: inputs set at the falling edge, model advanced at the rising edge, outputs checked at the next falling edge.
    task automatic cyc(input bit v, input u8 d, input bit fe, input bit rdy);
        rx_valid = v; rx_data = d; rx_frame_err = fe; out_ready = rdy;
        if (out_valid && rdy) got.push_back(out_data);
        @(posedge baud_clk);
        model_step(v, d, fe, rdy);
        @(negedge baud_clk);
        compare();
        if (pkt_done) c_done++;
        if (pkt_err) c_err++;
        if (out_valid) begin
            c_valid++;
            last_cmd = pkt_cmd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_frame_err = 1'b0; out_ready = 1'b0; rx_data = 8'd0;
        #1;
        model_reset();
        compare();
        @(negedge baud_clk);
        compare();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        got.delete(); c_done = 0; c_err = 0; c_valid = 0; last_cmd = 2'd0;
    endtask

    task automatic send(input bit rdy);
        foreach (stim[i]) cyc(1'b1, stim[i], 1'b0, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'd0, 1'b0, rdy);
    endtask

    task automatic chk_got(input string nm);
        chk({nm, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(nm, got[i], exp_q[i]);
    endtask

    task automatic rand_pkt();
        u8  b[$];
        u8  cmd, lb, x;
        int kind, len, fe_at;
        kind  = int'($urandom_range(0, 7));
        cmd   = 8'($urandom_range(0, 3));
        len   = int'($urandom_range(1, MAX_LEN));
        lb    = 8'(len);
        fe_at = -1;
        if (kind == 4) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
                x = 8'($urandom_range(0, 255));
                b.push_back((x == SYNC) ? 8'h00 : x);
            end
        end
        b.push_back(SYNC);
        if (kind == 0) cmd = 8'($urandom_range(4, 255));
        if (kind == 1) lb = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        b.push_back(cmd);
        b.push_back(lb);
        x = cmd ^ lb;
        for (int i = 0; i < len; i++) begin
            u8 p;
            p = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom_range(0, 255));
            b.push_back(p);
            x = x ^ p;
        end
        if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
        b.push_back(x);
        if (kind == 3) fe_at = int'($urandom_range(1, b.size() - 1));
        foreach (b[i]) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 3) != 0);
            cyc(1'b1, b[i], i == fe_at, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 300 && m_drain.size() != 0; k++)
            cyc($urandom_range(0, 4) == 0, 8'($urandom_range(0, 255)), 1'b0, $urandom_range(0, 3) != 0);
        if (m_drain.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL drain_timeout: got %0d bytes left want 0", m_drain.size());
            m_drain.delete();
        end
        idle(int'($urandom_range(0, 3)), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0; out_ready = 1'b0; rx_data = 8'd0;
        model_reset();
        @(negedge baud_clk);
        do_reset();

        // Basic packet, checksum 01^03^10^20^30 = 02.
        clear_log();
        stim = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
        send(1'b1);
        idle(5, 1'b1);
        exp_q = '{8'h10, 8'h20, 8'h30};
        chk_got("basic_data");
        chk("basic_done", c_done, 1);
        chk("basic_valid_cycles", c_valid, 3);
        chk("basic_cmd", last_cmd, 1);
        chk("basic_no_err", c_err, 0);

        // Same packet, wrong checksum.
        clear_log();
        stim = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00};
        send(1'b1);
        idle(3, 1'b1);
        chk("badchk_err", c_err, 1);
        chk("badchk_code", err_code, 3);
        chk("badchk_valid", c_valid, 0);
        chk("badchk_rts", rts, 1);

        // Oversize LEN, then a good one-byte packet (02^01^55 = 56).
        clear_log();
        stim = '{8'hA5, 8'h00, 8'h11};
        send(1'b1);
        idle(2, 1'b1);
        chk("badlen_err", c_err, 1);
        chk("badlen_code", err_code, 2);
        clear_log();
        stim = '{8'hA5, 8'h02, 8'h01, 8'h55, 8'h56};
        send(1'b1);
        idle(4, 1'b1);
        exp_q = '{8'h55};
        chk_got("after_badlen");
        chk("after_badlen_done", c_done, 1);

        // Back-pressure with bytes thrown at the block while it drains.
        clear_log();
        stim = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
        send(1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            chk("stall_data", out_data, 8'h10);
            chk("stall_rts", rts, 0);
        end
        idle(5, 1'b1);
        exp_q = '{8'h10, 8'h20, 8'h30};
        chk_got("stall_data_seq");
        chk("stall_done", c_done, 1);
        chk("stall_no_err", c_err, 0);

        // Framing error on the 2nd payload byte, then reset in the middle of a drain.
        clear_log();
        stim = '{8'hA5, 8'h00, 8'h02, 8'h11};
        send(1'b1);
        cyc(1'b1, 8'h22, 1'b1, 1'b1);
        idle(2, 1'b1);
        chk("frame_err", c_err, 1);
        chk("frame_code", err_code, 1);
        stim = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
        send(1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        do_reset();
        chk("rst_rts", rts, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cmd", pkt_cmd, 0);
        idle(3, 1'b1);
        chk("rst_no_done", c_done, 0);

        // Full-length packet, payload 00..0F; checksum 02^10^(xor 00..0F = 00) = 12.
        clear_log();
        stim = '{8'hA5, 8'h02, 8'h10};
        for (int i = 0; i < 16; i++) stim.push_back(8'(i));
        stim.push_back(8'h12);
        send(1'b1);
        idle(20, 1'b1);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        chk_got("full_data");
        chk("full_done", c_done, 1);

        for (int p = 0; p < 120; p++) rand_pkt();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
